// File: rtl/laser_sched_pkg.sv
// Shared constants for the laser event scheduler: register map, bit positions,
// debounce FSM encoding and the event word packer.
package laser_sched_pkg;

  localparam int NCH        = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int DB_W       = 16;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_DBNC       = 3'd1;
  localparam logic [2:0] REG_STATUS     = 3'd2;
  localparam logic [2:0] REG_EVENT      = 3'd3;
  localparam logic [2:0] REG_STATUS_W1C = 3'd4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MASK_LSB   = 4;
  localparam int CTRL_IRQ_EN_BIT = 8;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int EVT_CH_LSB = 0;
  localparam int EVT_ON_BIT = 2;
  localparam int EVT_TS_LSB = 16;

  localparam logic [15:0] DBNC_RST = 16'd1000;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_PEND_ON  = 2'd1,
    ST_ON       = 2'd2,
    ST_PEND_OFF = 2'd3
  } db_state_e;

  function automatic logic [31:0] evt_word(input logic [15:0] ts, input logic on,
                                           input logic [1:0] ch);
    logic [31:0] w;
    w = '0;
    w[EVT_TS_LSB +: 16]  = ts;
    w[EVT_ON_BIT]        = on;
    w[EVT_CH_LSB +: 2]   = ch;
    return w;
  endfunction

endpackage

// File: rtl/laser_debounce.sv
// One laser channel: 2-FF synchroniser, debounce FSM and counter. evt_on/evt_off
// are single-cycle registered pulses issued on the cycle the debounce completes.
module laser_debounce
  import laser_sched_pkg::*;
#(
  parameter int DB_W_P = DB_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              laser_raw,
  input  logic              chan_en,
  input  logic [DB_W_P-1:0] dbnc,
  output logic              evt_on,
  output logic              evt_off,
  output db_state_e         state_o
);

  logic              meta_q;
  logic              sync_q;
  db_state_e         state_q;
  logic [DB_W_P-1:0] cnt_q;
  logic              evt_on_q;
  logic              evt_off_q;
  logic [DB_W_P-1:0] dbnc_eff;
  logic [DB_W_P-1:0] cnt_inc;

  // A programmed debounce of zero behaves like one cycle.
  assign dbnc_eff = (dbnc == '0) ? DB_W_P'(1) : dbnc;
  assign cnt_inc  = cnt_q + DB_W_P'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      evt_on_q  <= 1'b0;
      evt_off_q <= 1'b0;
    end else begin
      meta_q    <= laser_raw;
      sync_q    <= meta_q;
      evt_on_q  <= 1'b0;
      evt_off_q <= 1'b0;
      cnt_q     <= '0;
      if (!chan_en) begin
        state_q <= ST_OFF;
      end else begin
        case (state_q)
          ST_OFF:
            if (sync_q) state_q <= ST_PEND_ON;
          ST_PEND_ON:
            if (!sync_q) begin
              state_q <= ST_OFF;
            end else if (cnt_inc == dbnc_eff) begin
              state_q  <= ST_ON;
              evt_on_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          ST_ON:
            if (!sync_q) state_q <= ST_PEND_OFF;
          ST_PEND_OFF:
            if (sync_q) begin
              state_q <= ST_ON;
            end else if (cnt_inc == dbnc_eff) begin
              state_q   <= ST_OFF;
              evt_off_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          default:
            state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign evt_on  = evt_on_q;
  assign evt_off = evt_off_q;
  assign state_o = state_q;

endmodule

// File: rtl/laser_event_scheduler.sv
// Laser beam event controller: debounced channels, round-robin scheduler, event FIFO
// and bus register file. Optional timestamp counter enabled by LASER_TIMESTAMP_EN.
module laser_event_scheduler
  import laser_sched_pkg::*;
#(
  parameter int FIFO_DEPTH_P = FIFO_DEPTH,
  parameter int DB_W_P       = DB_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  laser,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam int AW    = $clog2(FIFO_DEPTH_P);
  localparam int PTR_W = AW + 1;

  logic              ctrl_en_q, ctrl_en_d;
  logic [NCH-1:0]    ctrl_mask_q, ctrl_mask_d;
  logic              ctrl_irq_en_q, ctrl_irq_en_d;
  logic [DB_W_P-1:0] dbnc_q, dbnc_d;
  logic              ovf_q, ovf_d;
  logic [NCH-1:0]    slot_valid_q, slot_valid_d;
  logic [NCH-1:0]    slot_on_q, slot_on_d;
  logic [15:0]       slot_ts_q [NCH];
  logic [15:0]       slot_ts_d [NCH];
  logic [1:0]        rr_q, rr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       d_out_q, d_out_d;
  logic [31:0]       mem_q [FIFO_DEPTH_P];

  logic [NCH-1:0]    evt_on, evt_off, evt_on_m, evt_off_m, req;
  logic [NCH-1:0]    ch_en;
  db_state_e         ch_state [NCH];  // per-channel debug view of the debounce FSMs
  logic [15:0]       ts_now;
  logic [2:0]        reg_sel;
  logic              bus_rd, bus_wr, flush, pop, push, can_push, ovf_set, ovf_clr;
  logic              gnt_found, granted;
  logic [1:0]        gnt, idx;
  logic [PTR_W-1:0]  count;
  logic              empty, full;
  logic [31:0]       push_word, rd_word;
  logic              unused_bits;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_en[i] = ctrl_en_q & ~ctrl_mask_q[i];
    laser_debounce #(.DB_W_P(DB_W_P)) u_db (
      .clk       (clk),
      .resetn    (resetn),
      .laser_raw (laser[i]),
      .chan_en   (ch_en[i]),
      .dbnc      (dbnc_q),
      .evt_on    (evt_on[i]),
      .evt_off   (evt_off[i]),
      .state_o   (ch_state[i])
    );
  end

`ifdef LASER_TIMESTAMP_EN
  logic [9:0]  pre_q;
  logic [15:0] ts_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
      ts_q  <= '0;
    end else begin
      pre_q <= pre_q + 10'd1;
      if (pre_q == 10'h3FF) ts_q <= ts_q + 16'd1;
    end
  end
  assign ts_now = ts_q;
`else
  assign ts_now = 16'h0;
`endif

  assign bus_rd  = cs & rd;
  assign bus_wr  = cs & wr;
  assign reg_sel = addr[4:2];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == PTR_W'(FIFO_DEPTH_P));
  assign pop     = bus_rd && (reg_sel == REG_EVENT) && !empty;
  assign flush   = bus_wr && (reg_sel == REG_CTRL) && ctrl_en_q && !d_in[CTRL_EN_BIT];
  assign ovf_clr = bus_wr && (reg_sel == REG_STATUS_W1C) && d_in[ST_OVF_BIT];
  // A pop in the same cycle frees the slot the push lands in.
  assign can_push  = !full || pop;
  assign evt_on_m  = evt_on  & {NCH{ctrl_en_q}};
  assign evt_off_m = evt_off & {NCH{ctrl_en_q}};
  assign req       = slot_valid_q | evt_on_m | evt_off_m;

  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = rr_q + 2'(k);
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
    push      = gnt_found && can_push && !flush;
    push_word = slot_valid_q[gnt] ? evt_word(slot_ts_q[gnt], slot_on_q[gnt], gnt)
                                  : evt_word(ts_now, evt_on_m[gnt], gnt);
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_on_d    = slot_on_q;
    slot_ts_d    = slot_ts_q;
    ovf_set      = 1'b0;
    granted      = 1'b0;
    rr_d         = push ? gnt + 2'd1 : rr_q;
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    for (int i = 0; i < NCH; i++) begin
      granted = push && (gnt == 2'(i));
      if (evt_on_m[i] || evt_off_m[i]) begin
        // A fresh event bypasses its slot only when the slot is empty and it wins the grant.
        if (!(granted && !slot_valid_q[i])) begin
          if (slot_valid_q[i] && !granted) ovf_set = 1'b1;
          slot_valid_d[i] = 1'b1;
          slot_on_d[i]    = evt_on_m[i];
          slot_ts_d[i]    = ts_now;
        end
      end else if (granted) begin
        slot_valid_d[i] = 1'b0;
      end
    end
    if (flush) begin
      slot_valid_d = '0;
      rr_d         = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end
  end

  always_comb begin
    ctrl_en_d     = ctrl_en_q;
    ctrl_mask_d   = ctrl_mask_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    dbnc_d        = dbnc_q;
    ovf_d         = (ovf_q & ~ovf_clr) | ovf_set;
    if (bus_wr && (reg_sel == REG_CTRL)) begin
      ctrl_en_d     = d_in[CTRL_EN_BIT];
      ctrl_mask_d   = d_in[CTRL_MASK_LSB +: NCH];
      ctrl_irq_en_d = d_in[CTRL_IRQ_EN_BIT];
    end
    if (bus_wr && (reg_sel == REG_DBNC)) dbnc_d = d_in[DB_W_P-1:0];

    rd_word = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_word[CTRL_EN_BIT]           = ctrl_en_q;
        rd_word[CTRL_MASK_LSB +: NCH]  = ctrl_mask_q;
        rd_word[CTRL_IRQ_EN_BIT]       = ctrl_irq_en_q;
      end
      REG_DBNC: rd_word = 32'(dbnc_q);
      REG_STATUS, REG_STATUS_W1C: begin
        rd_word[ST_EMPTY_BIT]      = empty;
        rd_word[ST_FULL_BIT]       = full;
        rd_word[ST_OVF_BIT]        = ovf_q;
        rd_word[ST_COUNT_LSB +: 4] = 4'(count);
      end
      REG_EVENT: rd_word = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
      default:   rd_word = '0;
    endcase
    d_out_d = bus_rd ? rd_word : d_out_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_en_q     <= 1'b0;
      ctrl_mask_q   <= '0;
      ctrl_irq_en_q <= 1'b0;
      dbnc_q        <= DB_W_P'(DBNC_RST);
      ovf_q         <= 1'b0;
      slot_valid_q  <= '0;
      slot_on_q     <= '0;
      for (int i = 0; i < NCH; i++) slot_ts_q[i] <= '0;
      rr_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      d_out_q       <= '0;
    end else begin
      ctrl_en_q     <= ctrl_en_d;
      ctrl_mask_q   <= ctrl_mask_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      dbnc_q        <= dbnc_d;
      ovf_q         <= ovf_d;
      slot_valid_q  <= slot_valid_d;
      slot_on_q     <= slot_on_d;
      slot_ts_q     <= slot_ts_d;
      rr_q          <= rr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      d_out_q       <= d_out_d;
    end
  end

  // Storage only; occupancy is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

  assign d_out = d_out_q;
  assign irq   = ctrl_irq_en_q & ~empty;

  assign unused_bits = ^{d_in, addr, ch_state[0], ch_state[1], ch_state[2], ch_state[3]};

endmodule

// File: tb/tb_laser_event_scheduler.sv
// Directed self-checking bench for laser_event_scheduler with an expected-event queue.
// When built with LASER_TIMESTAMP_EN the timestamp field is excluded from event compares.
module tb_laser_event_scheduler;
  import laser_sched_pkg::*;

  logic        clk;
  logic        resetn;
  logic [31:0] d_in;
  logic        cs;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [3:0]  laser;
  logic [31:0] d_out;
  logic        irq;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_fail;

  laser_event_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .d_in   (d_in),
    .cs     (cs),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .laser  (laser),
    .d_out  (d_out),
    .irq    (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [2:0] r, input logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 32'h0041_0000 | {27'h0, r, 2'b00}; d_in = data;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic bus_read(input logic [2:0] r, output logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = 32'h0041_0000 | {27'h0, r, 2'b00};
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    data = d_out;
  endtask

  task automatic read_check(input string tag, input logic [2:0] r, input logic [31:0] expv);
    logic [31:0] v;
    bus_read(r, v);
    check(tag, v, expv);
  endtask

  // scoreboard pop/compare on each EVENT read
  task automatic read_event(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    bus_read(REG_EVENT, v);
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, v, 32'h0);
    end else begin
      e = exp_q.pop_front();
`ifdef LASER_TIMESTAMP_EN
      check(tag, {16'h0, v[15:0]}, {16'h0, e[15:0]});
`else
      check(tag, v, e);
`endif
    end
  endtask

  // flip one beam, record the event it should produce, let it debounce
  task automatic toggle(input int ch, input bit expect_evt);
    laser[ch] = ~laser[ch];
    if (expect_evt) exp_q.push_back(evt_word(16'h0, laser[ch], 2'(ch)));
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_irq(input string tag, input int limit);
    int c;
    c = 0;
    while (!irq && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(tag, {31'h0, irq}, 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int cyc;
    n_cmp  = 0;
    n_fail = 0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0; laser = 4'h0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // reset state
    check("rst_dout", d_out, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    read_check("rst_ctrl", REG_CTRL, 32'h0);
    read_check("rst_dbnc", REG_DBNC, 32'd1000);
    read_check("rst_status", REG_STATUS, 32'h1);

    // single channel on: 2 + 4 + 1 + 1 cycles to the push
    bus_write(REG_DBNC, 32'd4);
    bus_write(REG_CTRL, 32'h101);
    laser[0] = 1'b1;
    exp_q.push_back(32'h0000_0004);
    cyc = 0;
    while (!irq && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("on_latency", 32'(cyc), 32'd8);
    check("on_irq", {31'h0, irq}, 32'h1);
    read_check("on_status", REG_STATUS, 32'h100);
    read_event("ev_ch0_on");
    read_check("on_status_after", REG_STATUS, 32'h1);
    check("on_irq_clear", {31'h0, irq}, 32'h0);

    laser[0] = 1'b0;
    exp_q.push_back(32'h0000_0000);
    wait_irq("off_irq", 50);
    read_event("ev_ch0_off");

    // short glitch must be rejected
    laser[1] = 1'b1;
    repeat (3) @(negedge clk);
    laser[1] = 1'b0;
    repeat (20) @(negedge clk);
    read_check("glitch_status", REG_STATUS, 32'h1);
    check("glitch_fsm", 32'(dut.ch_state[1]), 32'(ST_OFF));

    // all four at once, from a fresh round-robin pointer
    do_reset();
    bus_write(REG_DBNC, 32'd4);
    bus_write(REG_CTRL, 32'h101);
    laser = 4'hF;
    for (int i = 0; i < 4; i++) exp_q.push_back(evt_word(16'h0, 1'b1, 2'(i)));
    repeat (16) @(negedge clk);
    read_check("simul_status", REG_STATUS, 32'h400);
    for (int i = 0; i < 4; i++) read_event("ev_simul_on");
    laser = 4'h0;
    for (int i = 0; i < 4; i++) exp_q.push_back(evt_word(16'h0, 1'b0, 2'(i)));
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) read_event("ev_simul_off");

    // fill the FIFO; the ninth event waits in its slot
    for (int i = 0; i < 8; i++) toggle(i % 4, 1'b1);
    read_check("full_status", REG_STATUS, 32'h802);
    toggle(0, 1'b1);
    read_check("full_pending", REG_STATUS, 32'h802);
    read_event("ev_full_pop");
    read_check("full_refill", REG_STATUS, 32'h802);
    for (int i = 0; i < 8; i++) read_event("ev_drain");
    read_check("drain_status", REG_STATUS, 32'h1);

    // read of an empty FIFO
    read_check("empty_event", REG_EVENT, 32'h0);
    read_check("empty_status", REG_STATUS, 32'h1);

    // overwrite of a pending slot sets ovf; w1c clears it
    for (int i = 0; i < 8; i++) toggle(i % 4, 1'b1);
    toggle(0, 1'b0);
    toggle(0, 1'b1);
    read_check("ovf_set", REG_STATUS, 32'h806);
    bus_write(REG_STATUS_W1C, 32'h4);
    read_check("ovf_clear", REG_STATUS, 32'h802);
    for (int i = 0; i < 9; i++) read_event("ev_ovf_drain");
    read_check("ovf_drained", REG_STATUS, 32'h1);

    // disable flushes queued events and silences channels
    toggle(1, 1'b0);
    read_check("pre_flush", REG_STATUS, 32'h100);
    bus_write(REG_CTRL, 32'h100);
    read_check("flush_status", REG_STATUS, 32'h1);
    check("flush_irq", {31'h0, irq}, 32'h0);
    toggle(1, 1'b0);
    read_check("disabled_status", REG_STATUS, 32'h1);

    // reset during PEND_ON drops the in-flight event
    laser = 4'h0;
    bus_write(REG_CTRL, 32'h001);
    laser[2] = 1'b1;
    repeat (4) @(negedge clk);
    check("pend_state", 32'(dut.ch_state[2]), 32'(ST_PEND_ON));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_dout", d_out, 32'h0);
    check("midrst_fsm", 32'(dut.ch_state[2]), 32'(ST_OFF));
    read_check("midrst_ctrl", REG_CTRL, 32'h0);
    repeat (12) @(negedge clk);
    read_check("midrst_status", REG_STATUS, 32'h1);
    laser = 4'h0;

    check("sb_left", 32'(exp_q.size()), 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
